ps2_rx_frame: RTL and testbench
===============================

// Module: ps2_rx_frame
// PURPOSE
//  Receives PS/2 device->host frames (start, 8 data LSB-first, odd parity, stop) from
//  the raw ps2 clock/data pins. Upstream front end of the keyboard input path: drives
//  the serial-in shift stage and hands the scancode byte to the decode logic downstream.
//  Synchronises the pins, detects falling edges, validates framing and parity, and
//  aborts stalled frames with a watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  5000  clk cycles allowed between ps2 clock falling edges mid-frame (>=16)
// PORTS
//  clk         input   1  system clock; all state changes on posedge
//  i_rst       input   1  asynchronous reset, active-high
//  i_en        input   1  1 = accept new frames; 0 = ignore start bits (frame in progress finishes)
//  i_ps2_clk   input   1  raw PS/2 clock pin (asynchronous, idle high)
//  i_ps2_dat   input   1  raw PS/2 data pin (asynchronous, idle high)
//  o_data      output  8  last correctly received byte; held until next good frame
//  o_valid     output  1  one-cycle pulse: o_data updated this cycle
//  o_err       output  1  one-cycle pulse: parity, stop-bit or timeout error
//  o_busy      output  1  1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE, o_data=8'h00, o_valid=0,
//   o_err=0, o_busy=0, bit count=0, watchdog=0, both sync chains and edge reg = 1
//   (so release of reset never produces a false falling edge).
//  Sync: 2-FF synchroniser per pin + one delay reg on clock; fall = prev & ~sync.
//   Pin fall to `fall` asserted: 3 clk. Data sampled from synchronised data in same cycle.
//  FSM (advances only on cycles with fall=1, except timeout):
//   IDLE:   fall & dat==0 & i_en -> DATA, count=0. fall & (dat==1 | ~i_en) -> stay.
//   DATA:   shift byte right, dat into bit 7; count++; after 8th bit -> PARITY.
//   PARITY: capture parity bit -> STOP.
//   STOP:   ok = (stop==1) & (^{byte,parity}==1). ok: o_data<=byte, o_valid=1 next cycle.
//           !ok: o_err=1, o_data unchanged. Either way -> IDLE.
//  Result latency: o_valid/o_err rise on the clk edge after the stop-bit fall is
//   detected; pulse exactly 1 cycle; o_valid and o_err never high together.
//  Watchdog: cleared on every fall and while IDLE; counts otherwise. When it reaches
//   TIMEOUT_CYCLES-1 with no fall -> IDLE, o_err pulse, partial byte discarded.
//   A fall in the same cycle as expiry wins (counter clears, frame continues).
//  i_en deasserted mid-frame has no effect until IDLE is reached.
//  o_busy = (state != IDLE), registered with state.
//  Back-to-back frames: start bit accepted on the first fall after returning to IDLE.
// TESTING
//  Frame 0x5A, parity 1, stop 1 -> one o_valid pulse, o_data=8'h5A, o_err stays 0.
//  Frame 0x00, parity 1 then frame 0xF0, parity 1 -> o_data 8'h00 then 8'hF0, two o_valid pulses.
//  Frame 0xF0 with parity 0 -> o_err 1-cycle pulse, o_valid 0, o_data holds previous value.
//  Frame 0x1C with stop bit 0 -> o_err pulse; a following good 0x1C frame -> o_valid, o_data=8'h1C.
//  Start + 3 data bits then ps2 clock idles TIMEOUT_CYCLES -> o_err pulse, o_busy drops;
//   next full frame 0x29 received correctly.
//  i_rst pulsed mid-frame -> all outputs 0 immediately; i_en=0 during a start bit -> no frame.

Source files
------------

// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if
// Bundles the PS/2 pin inputs, the receive enable and the received-byte
// outputs of the PS/2 frame receiver.
//   i_en       receive enable (driven by the master)
//   i_ps2_clk  raw PS/2 clock pin, idle high (driven by the master)
//   i_ps2_dat  raw PS/2 data pin, idle high (driven by the master)
//   o_data     last good byte (driven by the receiver)
//   o_valid    one-cycle pulse: o_data updated (driven by the receiver)
//   o_err      one-cycle pulse: parity/stop/timeout error (driven by the receiver)
//   o_busy     frame in progress (driven by the receiver)
interface ps2_rx_frame_if;
  logic       i_en;
  logic       i_ps2_clk;
  logic       i_ps2_dat;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_err;
  logic       o_busy;

  modport master (
    output i_en, i_ps2_clk, i_ps2_dat,
    input  o_data, o_valid, o_err, o_busy
  );

  modport slave (
    input  i_en, i_ps2_clk, i_ps2_dat,
    output o_data, o_valid, o_err, o_busy
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Receives PS/2 device->host frames (start, 8 data bits LSB first, odd parity,
// stop) from the raw pins and presents each good byte on o_data with a
// one-cycle o_valid pulse. Bad parity, bad stop bit or a stalled frame give a
// one-cycle o_err pulse instead.
//   clk    system clock
//   i_rst  asynchronous reset, active-high
//   bus    slave side of ps2_rx_frame_if (pins, enable, byte outputs)
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and parity, reporting result
module ps2_rx_frame #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic           clk,
  input  logic           i_rst,
  ps2_rx_frame_if.slave  bus
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_clk_sync;
  logic [1:0]        r_dat_sync;
  logic              r_clk_prev;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [2:0]        r_count;
  logic [WDOG_W-1:0] r_wdog;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_err;
  logic              r_busy;

  logic w_fall;
  logic w_dat;
  logic w_ok;
  logic w_expired;

  // Synchronisers reset to 1 (idle pin level) so leaving reset cannot look
  // like a falling edge.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], bus.i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], bus.i_ps2_dat};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_sync[1];
  assign w_dat     = r_dat_sync[1];
  assign w_ok      = w_dat & (^{r_shift, r_parity});
  assign w_expired = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
      r_count  <= 3'd0;
      r_wdog   <= '0;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == IDLE) begin
        r_wdog <= '0;
        if (w_fall && !w_dat && bus.i_en) begin
          r_state <= DATA;
          r_count <= 3'd0;
          r_busy  <= 1'b1;
        end
      end else if (w_fall) begin
        // A fall takes priority over a simultaneous watchdog expiry.
        r_wdog <= '0;
        case (r_state)
          DATA: begin
            r_shift <= {w_dat, r_shift[7:1]};
            r_count <= r_count + 3'd1;
            if (r_count == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_dat;
            r_state  <= STOP;
          end
          STOP: begin
            if (w_ok) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_expired) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
        r_wdog  <= '0;
      end else begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_err   = r_err;
  assign bus.o_busy  = r_busy;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame
// Directed and randomized PS/2 frames against a reference model that derives
// each frame's outcome directly from the frame rules (odd parity over data and
// parity bit, stop bit high, watchdog on stalled clock).
module tb_ps2_rx_frame;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_rx_frame_if bus ();

  ps2_rx_frame #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int shape_bad = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;
  logic [7:0] valid_q[$];
  logic [7:0] exp_data = 8'h00;

  // Output monitor: record pulses and flag overlapping or stretched pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid) begin
        n_valid <= n_valid + 1;
        valid_q.push_back(bus.o_data);
      end
      if (bus.o_err) n_err <= n_err + 1;
      if ((bus.o_valid && bus.o_err) || (bus.o_valid && prev_v) || (bus.o_err && prev_e))
        shape_bad <= shape_bad + 1;
      prev_v <= bus.o_valid;
      prev_e <= bus.o_err;
    end else begin
      prev_v <= 1'b0;
      prev_e <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.i_ps2_dat = b;
    wait_clk(5);
    bus.i_ps2_clk = 1'b0;
    wait_clk(10);
    bus.i_ps2_clk = 1'b1;
    wait_clk(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic drop_en);
    send_bit(1'b0);
    if (drop_en) bus.i_en = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stp);
    bus.i_ps2_dat = 1'b1;
    if (drop_en) bus.i_en = 1'b1;
  endtask

  // Reference: a frame is good when the stop bit is 1 and the total count of
  // ones over data+parity is odd. Accept=0 means the start bit is ignored.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                           input logic stp, input logic drop_en, input logic accept);
    int  nv0, ne0;
    bit  good;
    nv0  = n_valid;
    ne0  = n_err;
    good = (stp == 1'b1) && (($countones({b, par}) % 2) == 1);
    send_frame(b, par, stp, drop_en);
    wait_clk(10);
    chk({tag, "_valid_cnt"}, n_valid - nv0, (accept && good) ? 1 : 0);
    chk({tag, "_err_cnt"},   n_err - ne0,   (accept && !good) ? 1 : 0);
    if (accept && good) begin
      exp_data = b;
      if (valid_q.size() > 0) chk({tag, "_q_data"}, valid_q[$], b);
      else chk({tag, "_q_empty"}, 0, 1);
    end
    chk({tag, "_data"}, bus.o_data, exp_data);
    chk({tag, "_busy"}, bus.o_busy, 0);
  endtask

  initial begin
    int nv0, ne0;
    logic [7:0] rb;
    logic rp, rs;
    int kind;

    bus.i_en      = 1'b1;
    bus.i_ps2_clk = 1'b1;
    bus.i_ps2_dat = 1'b1;
    wait_clk(4);
    chk("rst_data",  bus.o_data, 8'h00);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_err",   bus.o_err, 0);
    chk("rst_busy",  bus.o_busy, 0);
    rst = 1'b0;
    wait_clk(10);
    chk("post_rst_busy", bus.o_busy, 0);
    chk("post_rst_err",  n_err, 0);

    run_frame("f5a", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);

    // Back-to-back 0x00 then 0xF0.
    nv0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    wait_clk(10);
    chk("b2b_cnt", n_valid - nv0, 2);
    if (valid_q.size() >= 2) begin
      chk("b2b_first",  valid_q[valid_q.size()-2], 8'h00);
      chk("b2b_second", valid_q[valid_q.size()-1], 8'hF0);
    end else chk("b2b_qsize", valid_q.size(), 2);
    exp_data = 8'hF0;
    chk("b2b_data", bus.o_data, 8'hF0);

    run_frame("badpar", 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_frame("badstop", 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame("f1c", 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);

    // Stalled frame: start + 3 data bits, then the clock idles.
    ne0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.i_ps2_dat = 1'b1;
    wait_clk(TMO / 2);
    chk("tmo_busy_mid", bus.o_busy, 1);
    chk("tmo_no_err_early", n_err - ne0, 0);
    wait_clk(TMO);
    chk("tmo_err", n_err - ne0, 1);
    chk("tmo_busy", bus.o_busy, 0);
    chk("tmo_data_hold", bus.o_data, exp_data);
    run_frame("f29", 8'h29, 1'b0, 1'b1, 1'b0, 1'b1);

    // Enable dropped mid-frame: frame still completes.
    run_frame("endrop", 8'h33, 1'b1, 1'b1, 1'b1, 1'b1);

    // Enable low at the start bit: whole frame ignored.
    bus.i_en = 1'b0;
    run_frame("endis", 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.i_en = 1'b1;

    // Reset in the middle of a frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_clk(2);
    #1 rst = 1'b1;
    #1;
    chk("mrst_data",  bus.o_data, 8'h00);
    chk("mrst_valid", bus.o_valid, 0);
    chk("mrst_err",   bus.o_err, 0);
    chk("mrst_busy",  bus.o_busy, 0);
    bus.i_ps2_dat = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    exp_data = 8'h00;
    wait_clk(10);
    chk("mrst_after_busy", bus.o_busy, 0);
    run_frame("f_after_rst", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);

    // Randomized frames with occasional parity/stop corruption.
    for (int i = 0; i < 20; i++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 3);
      rp   = (($countones(rb) % 2) == 0);
      rs   = 1'b1;
      if (kind == 0) rp = ~rp;
      if (kind == 1) rs = 1'b0;
      run_frame($sformatf("rnd%0d", i), rb, rp, rs, 1'b0, 1'b1);
    end

    chk("pulse_shape", shape_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
